// File: rtl/game_select_ctrl_pkg.sv
// rtl/game_select_ctrl_pkg.sv - game codes, default widths and FSM state encoding
package game_select_ctrl_pkg;

  localparam int NUM_GAMES_DEF = 8;
  localparam int GAME_W_DEF    = 4;

  localparam logic [GAME_W_DEF-1:0] MARIO       = 4'd0;
  localparam logic [GAME_W_DEF-1:0] DONKEY_KONG = 4'd1;
  localparam logic [GAME_W_DEF-1:0] PACMAN      = 4'd2;
  localparam logic [GAME_W_DEF-1:0] GALAGA      = 4'd3;
  localparam logic [GAME_W_DEF-1:0] DEFENDER2   = 4'd4;
  localparam logic [GAME_W_DEF-1:0] TENNIS      = 4'd5;
  localparam logic [GAME_W_DEF-1:0] GOLF        = 4'd6;
  localparam logic [GAME_W_DEF-1:0] PINBALL     = 4'd7;

  typedef logic [1:0] state_t;
  localparam state_t IDLE = 2'd0;
  localparam state_t REQ  = 2'd1;
  localparam state_t HOLD = 2'd2;

endpackage

// File: rtl/game_select_ctrl_sw_debounce.sv
// rtl/game_select_ctrl_sw_debounce.sv - 2-flop synchroniser plus whole-bus debounce
module sw_debounce #(
  parameter int WIDTH  = 10,
  parameter int CYCLES = 50000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] stable,
  output logic             changed
);

  localparam int CNT_W = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CYCLES - 1);

  logic [WIDTH-1:0] sync1, sync2, cand;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             settle;

  always_comb begin
    if (sync2 != cand)
      cnt_next = '0;
    else if (cnt == CNT_MAX)
      cnt_next = cnt;
    else
      cnt_next = cnt + CNT_W'(1);
  end

  // When settling, cand already equals sync2 (or is being loaded from it), so sync2 is the accepted pattern.
  assign settle = (cnt_next == CNT_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1   <= '0;
      sync2   <= '0;
      cand    <= '0;
      cnt     <= '0;
      stable  <= '0;
      changed <= 1'b0;
    end else begin
      sync1   <= din;
      sync2   <= sync1;
      cand    <= sync2;
      cnt     <= cnt_next;
      changed <= settle && (sync2 != stable);
      if (settle)
        stable <= sync2;
    end
  end

endmodule

// File: rtl/game_select_ctrl.sv
// rtl/game_select_ctrl.sv - switch decode and swap handshake FSM for game selection
// Optional GAME_SEL_AUTO_EN: a valid debounced pattern change starts a swap without commit.
module game_select_ctrl
  import game_select_ctrl_pkg::*;
#(
  parameter int NUM_SW          = 10,
  parameter int NUM_GAMES       = NUM_GAMES_DEF,
  parameter int GAME_W          = GAME_W_DEF,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int HOLD_CYCLES     = 16,
  parameter int DEFAULT_GAME    = int'(MARIO)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_SW-1:0] sw,
  input  logic              commit,
  input  logic              swap_ack,
  output logic [GAME_W-1:0] game,
  output logic              swap_req,
  output logic [GAME_W-1:0] pend_game,
  output logic              core_hold,
  output logic              sel_err
);

`ifdef GAME_SEL_AUTO_EN
  localparam bit AUTO_EN = 1'b1;
`else
  localparam bit AUTO_EN = 1'b0;
`endif

  localparam int HCNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HCNT_W-1:0] HCNT_MAX = HCNT_W'(HOLD_CYCLES - 1);

  logic [NUM_SW-1:0] stable;
  logic              stable_chg;
  logic [GAME_W-1:0] code;
  logic              high_set, valid, trig, start_swap;
  state_t            state;
  logic [HCNT_W-1:0] hold_cnt;

  sw_debounce #(
    .WIDTH (NUM_SW),
    .CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk    (clk),
    .rst    (rst),
    .din    (sw),
    .stable (stable),
    .changed(stable_chg)
  );

  // Any set bit above the game range poisons the pattern, even if it is the only one.
  always_comb begin
    code     = '0;
    high_set = 1'b0;
    for (int i = 0; i < NUM_SW; i++) begin
      if (stable[i]) begin
        if (i < NUM_GAMES)
          code = GAME_W'(i);
        else
          high_set = 1'b1;
      end
    end
    valid = ($countones(stable) == 1) && !high_set;
  end

  assign trig       = commit || (AUTO_EN && stable_chg);
  assign start_swap = trig && valid && (code != game);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      game      <= GAME_W'(DEFAULT_GAME);
      pend_game <= GAME_W'(DEFAULT_GAME);
      swap_req  <= 1'b0;
      core_hold <= 1'b0;
      sel_err   <= 1'b0;
      hold_cnt  <= '0;
    end else begin
      sel_err <= 1'b0;
      case (state)
        IDLE: begin
          if (start_swap) begin
            pend_game <= code;
            swap_req  <= 1'b1;
            core_hold <= 1'b1;
            state     <= REQ;
          end else if (commit && !valid) begin
            sel_err <= 1'b1;
          end
        end
        REQ: begin
          if (swap_ack) begin
            game     <= pend_game;
            swap_req <= 1'b0;
            hold_cnt <= '0;
            state    <= HOLD;
          end
        end
        HOLD: begin
          if (hold_cnt == HCNT_MAX) begin
            core_hold <= 1'b0;
            state     <= IDLE;
          end else begin
            hold_cnt <= hold_cnt + HCNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_game_select_ctrl.sv
// tb/tb_game_select_ctrl.sv - scoreboard bench with directed and randomized selection traffic
module tb_game_select_ctrl;

  localparam int NSW    = 10;
  localparam int NG     = 8;
  localparam int GW     = 4;
  localparam int DEB    = 8;
  localparam int HOLD_C = 6;

  localparam int EV_REQ  = 1;
  localparam int EV_GAME = 2;
  localparam int EV_FALL = 3;
  localparam int EV_ERR  = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [NSW-1:0] sw = '0;
  logic           commit = 1'b0;
  logic           swap_ack = 1'b0;
  logic [GW-1:0]  game, pend_game;
  logic           swap_req, core_hold, sel_err;

  game_select_ctrl #(
    .NUM_SW(NSW), .NUM_GAMES(NG), .GAME_W(GW),
    .DEBOUNCE_CYCLES(DEB), .HOLD_CYCLES(HOLD_C), .DEFAULT_GAME(0)
  ) dut (
    .clk(clk), .rst(rst), .sw(sw), .commit(commit), .swap_ack(swap_ack),
    .game(game), .swap_req(swap_req), .pend_game(pend_game),
    .core_hold(core_hold), .sel_err(sel_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct { int kind; int val; int at; } ev_t;
  ev_t expq[$];

  int checks = 0;
  int failures = 0;
  int model_game = 0;
  int model_pend = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int k, input int v, input int at);
    ev_t e;
    e.kind = k; e.val = v; e.at = at;
    expq.push_back(e);
  endtask

  task automatic chk(input string nm, input int got_v, input int exp_v);
    checks++;
    if (got_v != exp_v) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d at cycle %0d", nm, got_v, exp_v, cyc);
    end
  endtask

  // Game index of a one-hot pattern within the game range, -1 otherwise.
  function automatic int model_decode(input logic [NSW-1:0] p);
    logic [NSW-1:0] one;
    if ($countones(p) != 1) return -1;
    for (int i = 0; i < NG; i++) begin
      one = NSW'(1) << i;
      if (p == one) return i;
    end
    return -1;
  endfunction

  task automatic got(input int k, input int v, input string nm);
    ev_t e;
    checks++;
    if (expq.size() == 0) begin
      failures++;
      $display("FAIL %s unexpected event value=%0d at cycle %0d, none expected", nm, v, cyc);
    end else begin
      e = expq.pop_front();
      if (e.kind != k || e.val != v || e.at != cyc) begin
        failures++;
        $display("FAIL %s got kind=%0d value=%0d cycle=%0d expected kind=%0d value=%0d cycle=%0d",
                 nm, k, v, cyc, e.kind, e.val, e.at);
      end
    end
  endtask

  logic          p_req = 1'b0, p_hold = 1'b0;
  logic [GW-1:0] p_game = '0;

  always @(negedge clk) begin
    if (!rst) begin
      if (swap_req && !p_req) begin
        got(EV_REQ, int'(pend_game), "swap_req_rise");
        chk("core_hold_with_req", int'(core_hold), 1);
      end
      if (swap_req && p_req)
        chk("pend_game_frozen", int'(pend_game), model_pend);
      if (game != p_game) begin
        got(EV_GAME, int'(game), "game_change");
        chk("swap_req_drop_on_ack", int'(swap_req), 0);
      end
      if (p_hold && !core_hold)
        got(EV_FALL, 0, "core_hold_fall");
      if (sel_err)
        got(EV_ERR, 0, "sel_err_pulse");
    end
    p_req  = swap_req;
    p_hold = core_hold;
    p_game = game;
  end

  task automatic settle(input logic [NSW-1:0] p);
    sw = p;
    repeat (DEB + 2) tick();
  endtask

  // Commit the current (settled) pattern and, if a swap starts, finish it with an ack.
  task automatic flow(input bit glitch, input int ack_dly, input bit ack_commit);
    int code, c, a;
    logic [NSW-1:0] saved;
    code = model_decode(sw);
    c = cyc;
    if (code < 0) push(EV_ERR, 0, c + 1);
    else if (code != model_game) begin
      push(EV_REQ, code, c + 1);
      model_pend = code;
    end
    commit = 1'b1; tick(); commit = 1'b0;
    if (code >= 0 && code != model_game) begin
      tick();
      if (glitch) begin
        saved = sw;
        sw = (code == 5) ? NSW'(1) << 4 : NSW'(1) << 5;
        repeat (DEB + 3) tick();
        commit = 1'b1; tick(); commit = 1'b0;
        sw = saved;
      end
      repeat (ack_dly) tick();
      a = cyc;
      push(EV_GAME, code, a + 1);
      push(EV_FALL, 0, a + 1 + HOLD_C);
      swap_ack = 1'b1; commit = ack_commit; tick();
      swap_ack = 1'b0; commit = 1'b0;
      model_game = code;
      repeat (HOLD_C + 2) tick();
    end else begin
      repeat (2) tick();
    end
  endtask

  initial begin
    int n, c, a, r, b0, b1;
    logic [NSW-1:0] p;

    rst = 1'b1;
    repeat (3) tick();
    chk("reset_game", int'(game), 0);
    chk("reset_swap_req", int'(swap_req), 0);
    chk("reset_core_hold", int'(core_hold), 0);
    chk("reset_sel_err", int'(sel_err), 0);
    chk("reset_pend_game", int'(pend_game), 0);
    rst = 1'b0;
    repeat (3) tick();

    settle(10'b0000000100);
    flow(1'b0, 5, 1'b0);

    settle(10'b0000000110); flow(1'b0, 0, 1'b0);
    settle(10'b0100000000); flow(1'b0, 0, 1'b0);
    settle(10'b0000000000); flow(1'b0, 0, 1'b0);

    // Bounce on bit 3, then settle on bit 3: a commit one cycle early still sees the old pattern.
    sw = '0;
    repeat (DEB + 4) tick();
    for (int i = 0; i < 10; i++) begin
      sw = sw ^ NSW'(8);
      repeat (DEB / 2) tick();
    end
    sw = NSW'(8);
    n = cyc;
    repeat (DEB + 1) tick();
    c = cyc;
    push(EV_ERR, 0, c + 1);
    commit = 1'b1; tick(); commit = 1'b0;
    chk("bounce_commit_cycle", cyc, n + DEB + 2);
    flow(1'b0, 2, 1'b0);

    settle(10'b0000000010);
    flow(1'b1, 3, 1'b1);

    // Reset while a swap is outstanding.
    settle(10'b0010000000);
    c = cyc;
    push(EV_REQ, 7, c + 1);
    model_pend = 7;
    commit = 1'b1; tick(); commit = 1'b0;
    repeat (3) tick();
    sw = '0;
    rst = 1'b1; tick();
    chk("midreq_rst_game", int'(game), 0);
    chk("midreq_rst_swap_req", int'(swap_req), 0);
    chk("midreq_rst_core_hold", int'(core_hold), 0);
    chk("midreq_rst_sel_err", int'(sel_err), 0);
    chk("midreq_rst_pend_game", int'(pend_game), 0);
    tick();
    rst = 1'b0;
    model_game = 0;
    repeat (DEB + 4) tick();

`ifdef GAME_SEL_AUTO_EN
    sw = NSW'(1) << 6;
    n = cyc;
    model_pend = 6;
    push(EV_REQ, 6, n + DEB + 3);
    repeat (DEB + 5) tick();
    a = cyc;
    push(EV_GAME, 6, a + 1);
    push(EV_FALL, 0, a + 1 + HOLD_C);
    swap_ack = 1'b1; tick(); swap_ack = 1'b0;
    model_game = 6;
    repeat (HOLD_C + 2) tick();
`endif

    for (int it = 0; it < 40; it++) begin
      r = $urandom_range(0, 7);
      if (r <= 3) p = NSW'(1) << $urandom_range(0, NG - 1);
      else if (r == 4) p = NSW'(1) << $urandom_range(NG, NSW - 1);
      else if (r == 5) p = '0;
      else begin
        b0 = $urandom_range(0, NSW - 1);
        b1 = (b0 + $urandom_range(1, NSW - 1)) % NSW;
        p = (NSW'(1) << b0) | (NSW'(1) << b1);
      end
      sw = p;
      if ($urandom_range(0, 3) == 0) begin
        swap_ack = 1'b1; tick(); swap_ack = 1'b0;
        repeat (DEB + 1) tick();
      end else begin
        repeat (DEB + 2) tick();
      end
      flow(1'($urandom_range(0, 1)), $urandom_range(0, 6), 1'($urandom_range(0, 1)));
    end

    repeat (10) tick();
    chk("scoreboard_leftover", expq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/game_select_ctrl.md
Name: game_select_ctrl

Overview:
Parametrised game-selection controller between the board switches and the cartridge memory/NES core.
- Synchronises and debounces the switch bank, then decodes a one-hot switch pattern into a game code.
- Commits a new game only through a swap handshake with the cartridge loader.
- Holds the core in reset while the swap is in progress.

Parameters:
NUM_SW, 10, width of the switch bank
NUM_GAMES, 8, number of selectable games; switch bits [NUM_GAMES-1:0] map to game codes 0..NUM_GAMES-1
GAME_W, 4, width of the game code; must satisfy 2**GAME_W >= NUM_GAMES
DEBOUNCE_CYCLES, 50000, consecutive stable clk cycles required before a switch pattern is accepted; must be >= 1
HOLD_CYCLES, 16, clk cycles core_hold stays high after swap_ack
DEFAULT_GAME, 0, game code after reset (MARIO)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
sw  in  NUM_SW  raw asynchronous switch inputs
commit  in  1  one-cycle pulse (reset button edge) requesting a game change
swap_ack  in  1  one-cycle pulse from the cartridge loader: new ROM mapped
game  out  GAME_W  currently committed game code
swap_req  out  1  level request to the loader to switch to pend_game
pend_game  out  GAME_W  game code being requested; valid while swap_req=1
core_hold  out  1  holds the NES core in reset during a swap
sel_err  out  1  one-cycle pulse: commit arrived with an invalid switch pattern

Behaviour:
- Reset (rst=1 at a clk edge) sets the following:
  - game=DEFAULT_GAME; swap_req=0, core_hold=0, sel_err=0.
  - pend_game=DEFAULT_GAME; FSM=IDLE.
  - Synchroniser flops, candidate, stable pattern and debounce counter all 0.
  - Reset mid-swap aborts the swap; the loader must tolerate swap_req dropping without an ack.
- Synchroniser: 2 flops per bit.
- Debounce (whole bus, not per bit):
  - If the synced value differs from candidate: candidate<=synced, counter<=0.
  - Otherwise the counter increments, saturating at DEBOUNCE_CYCLES-1.
  - When the counter equals DEBOUNCE_CYCLES-1, stable<=candidate.
  - Latency from a clean sw change to stable update: DEBOUNCE_CYCLES+2 clk.
- Decode (combinational from stable): valid iff exactly one bit is set, that bit index is < NUM_GAMES, and bits [NUM_SW-1:NUM_GAMES] are 0. Decoded code = bit index. All-zero and multi-bit patterns are invalid.
- FSM states IDLE, REQ, HOLD:
  - IDLE, commit=1:
    - Valid and code!=game: pend_game<=code, swap_req<=1, core_hold<=1, go to REQ.
    - Valid and code==game: no action.
    - Invalid: sel_err=1 for exactly the next cycle; stay in IDLE.
  - REQ: swap_req and core_hold stay high; pend_game is frozen (switch changes ignored). On swap_ack: game<=pend_game, swap_req<=0, hold counter<=0, go to HOLD.
  - HOLD: core_hold=1; counter increments each cycle. When the counter reaches HOLD_CYCLES-1: core_hold<=0, go to IDLE. core_hold therefore falls HOLD_CYCLES cycles after the ack edge.
- Other boundary rules:
  - commit is ignored outside IDLE.
  - swap_ack is ignored outside REQ.
  - commit and swap_ack arriving in the same cycle while in REQ: the ack is processed and the commit is dropped.
  - game changes only on the swap_ack edge; it never glitches.

Optional Feature:
GAME_SEL_AUTO_EN
- Defined: in IDLE, a stable-pattern update that decodes valid with code!=game triggers the REQ transition without commit; commit behaves as above. Invalid patterns never pulse sel_err automatically, only on commit.
- Undefined: changes occur only on commit.

Decomposition:
- Package Games holds:
  - game code constants (MARIO=0, DONKEY_KONG=1, PACMAN=2, GALAGA=3, DEFENDER2=4, TENNIS=5, GOLF=6, PINBALL=7)
  - NUM_GAMES and GAME_W defaults
  - the FSM state enum (IDLE, REQ, HOLD)
- One sub-module, sw_debounce (parametrised WIDTH, CYCLES), containing synchroniser, candidate, counter and stable register.
- Decode and FSM live in game_select_ctrl.

Test Plan:
- Reset with sw=0 -> game=0, swap_req=0, core_hold=0, sel_err=0.
- sw=10'b0000000100, wait DEBOUNCE_CYCLES+2, pulse commit -> next cycle swap_req=1, pend_game=2, core_hold=1. Ack after 5 cycles -> game=2 on ack edge; core_hold falls HOLD_CYCLES later.
- sw=10'b0000000110 then commit -> sel_err single-cycle pulse; game, swap_req and core_hold unchanged. Same result for sw=10'b0100000000 and for sw=0.
- Switch bounce: toggle sw bit 3 every DEBOUNCE_CYCLES/2 cycles for 10 toggles, then hold -> stable updates only DEBOUNCE_CYCLES+2 after the last toggle; an earlier commit gives sel_err or no-op.
- During REQ: change sw to game 5 and pulse commit -> pend_game stays at the old request; ack commits the old code. Assert rst mid-REQ -> all outputs return to reset values the next cycle.
- With GAME_SEL_AUTO_EN defined: set sw to game 6 with no commit -> swap_req rises 1 cycle after the stable update, pend_game=6.
